// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and defaults for the FIFO-fed UART transmitter.
//   uart_state_e : transmitter FSM state encoding
//   DEF_CLK_FREQ : default clock frequency in Hz
//   DEF_BAUD     : default line rate in bit/s
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

   localparam int DEF_CLK_FREQ = 27000000;
   localparam int DEF_BAUD     = 115200;

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_state_e;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      STOP   = 3'd5
   } uart_state_e;
`endif

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period counter for the UART transmitter.
//   clock    : system clock
//   rst_b    : asynchronous active-low reset
//   clear    : restart the period (counter to 0 on the next edge)
//   bit_done : high for the last clock of each bit period
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic clock,
   input  logic rst_b,
   input  logic clear,
   output logic bit_done
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      bit_done = (cnt_q == CNT_LAST);
      if (clear || bit_done) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- UART transmitter that pops bytes from a show-ahead FIFO.
//   clock      : system clock, all state on rising edge
//   reset_n    : asynchronous active-low reset, release synchronised
//   fifo_empty : FIFO empty flag (connect to fifo empty)
//   fifo_data  : FIFO head word (connect to fifo data_out)
//   fifo_read  : one-cycle pop strobe (connect to fifo read_en)
//   tx         : serial line, idle high, 8 data bits LSB first
//   busy       : high from fetch until the end of the stop bit
// Optional feature macro: FIFO_UART_TX_PARITY_EN inserts an even parity bit
// (8E1); without it the frame is 8N1.
//
// state  | meaning
// IDLE   | line high, pop and latch a byte when the FIFO is not empty
// FETCH  | one-cycle gap after the pop, line high
// START  | start bit, line low
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit, line high
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read,
   output logic       tx,
   output logic       busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        rst_meta_q, run_q;
   logic        baud_clear;
   logic        bit_done;

   // Reset asserts asynchronously everywhere, but the FSM only starts acting
   // once run_q has passed through two flops after release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         run_q      <= rst_meta_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         bit_idx_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (run_q && !fifo_empty) begin
               shift_d = fifo_data;
               state_d = FETCH;
            end
         end
         FETCH: state_d = START;
         START: begin
            if (bit_done) state_d = DATA;
         end
         DATA: begin
            if (bit_done) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Every state change restarts the bit period; IDLE holds the counter at 0.
   assign baud_clear = (state_d != state_q) || (state_q == IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clock    (clock),
      .rst_b    (reset_n),
      .clear    (baud_clear),
      .bit_done (bit_done)
   );

   always_comb begin
      tx        = 1'b1;
      fifo_read = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE:   fifo_read = run_q && !fifo_empty;
         START:  tx = 1'b0;
         DATA:   tx = shift_q[bit_idx_q];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: tx = ^shift_q;
`endif
         default: tx = 1'b1;
      endcase
   end

endmodule
